// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port bundle: scanout read, dither write stream and the SPRAM side.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              mem_wen;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rd_data,
        output rd_valid, rd_data, wr_ready, mem_wen, mem_wr_addr, mem_wr_data, mem_rd_addr
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rd_data,
        input  rd_valid, rd_data, wr_ready, mem_wen, mem_wr_addr, mem_wr_data, mem_rd_addr
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win, dither writes wait in a
// small FIFO and drain on any cycle without a read.
module fb_port_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int WQ_DEPTH    = 4,
    parameter int STALL_LIMIT = 32
) (
    input  logic                      clk_16mhz,
    input  logic                      reset,
    fb_port_arbiter_if.slave          bus,
    input  logic                      stat_clear,
    output logic [$clog2(WQ_DEPTH):0] wq_level,
    output logic [15:0]               wr_drop_count,
    output logic                      wr_stall
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [WQ_DEPTH];
    logic [DATA_W-1:0] data_mem [WQ_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              wr_stall_q, wr_stall_d;

    logic full, empty, push, pop, drop, stall_evt;

    always_comb begin
        full      = (level_q == LVL_W'(WQ_DEPTH));
        empty     = (level_q == '0);
        // Ready comes from the registered level only, so a pop never frees a full queue early.
        push      = bus.wr_valid && !full;
        drop      = bus.wr_valid && full;
        pop       = !bus.rd_req && !empty;
        stall_evt = bus.rd_req && !empty;

        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d   = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        rd_addr_d = bus.rd_req ? bus.rd_addr : rd_addr_q;

        // A drop in the same cycle as stat_clear leaves the count at one.
        if (stat_clear)
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
        else
            drop_cnt_d = drop_cnt_q;

        if (!stall_evt)
            stall_cnt_d = '0;
        else if (stall_cnt_q == 16'(STALL_LIMIT))
            stall_cnt_d = stall_cnt_q;
        else
            stall_cnt_d = stall_cnt_q + 16'd1;

        if (stall_cnt_d == 16'(STALL_LIMIT))
            wr_stall_d = 1'b1;
        else if (stat_clear)
            wr_stall_d = 1'b0;
        else
            wr_stall_d = wr_stall_q;
    end

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
            wr_stall_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= bus.rd_req;
            drop_cnt_q  <= drop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            wr_stall_q  <= wr_stall_d;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (push && !reset) begin
            addr_mem[wr_ptr_q] <= bus.wr_addr;
            data_mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        bus.wr_ready    = !full;
        bus.mem_wen     = pop;
        bus.mem_wr_addr = addr_mem[rd_ptr_q];
        bus.mem_wr_data = data_mem[rd_ptr_q];
        bus.mem_rd_addr = bus.rd_req ? bus.rd_addr : rd_addr_q;
        bus.rd_valid    = rd_valid_q;
        bus.rd_data     = bus.mem_rd_data;
        wq_level        = level_q;
        wr_drop_count   = drop_cnt_q;
        wr_stall        = wr_stall_q;
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus a random phase, checked every
// cycle against a reference model whose write queue doubles as the scoreboard.
module tb_fb_port_arbiter;
    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 16;
    localparam int WQ_DEPTH    = 4;
    localparam int STALL_LIMIT = 8;
    localparam int LVL_W       = $clog2(WQ_DEPTH) + 1;

    logic clk_16mhz = 1'b0;
    logic reset;
    logic stat_clear;
    logic [LVL_W-1:0] wq_level;
    logic [15:0]      wr_drop_count;
    logic             wr_stall;

    always #5 clk_16mhz = ~clk_16mhz;

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk_16mhz    (clk_16mhz),
        .reset        (reset),
        .bus          (bus),
        .stat_clear   (stat_clear),
        .wq_level     (wq_level),
        .wr_drop_count(wr_drop_count),
        .wr_stall     (wr_stall)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               mq[$];
    logic [ADDR_W-1:0] m_rd_addr;
    logic              m_rd_valid;
    logic [15:0]       m_drop;
    logic              m_stall;
    int unsigned       m_cnt;
    int unsigned       n_checks = 0;
    int unsigned       n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd_addr  = '0;
        m_rd_valid = 1'b0;
        m_drop     = '0;
        m_stall    = 1'b0;
        m_cnt      = 0;
    endtask

    task automatic tick();
        int  sz;
        bit  exp_wen, push, drop, evt;
        @(negedge clk_16mhz);
        sz      = mq.size();
        exp_wen = !bus.rd_req && sz != 0;
        chk("wr_ready", 32'(bus.wr_ready), 32'(sz < WQ_DEPTH));
        chk("wq_level", 32'(wq_level), 32'(sz));
        chk("mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
        if (exp_wen) begin
            chk("mem_wr_addr", 32'(bus.mem_wr_addr), 32'(mq[0].a));
            chk("mem_wr_data", 32'(bus.mem_wr_data), 32'(mq[0].d));
        end
        chk("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(bus.rd_req ? bus.rd_addr : m_rd_addr));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        if (m_rd_valid) chk("rd_data", 32'(bus.rd_data), 32'(bus.mem_rd_data));
        chk("drop_count", 32'(wr_drop_count), 32'(m_drop));
        chk("wr_stall", 32'(wr_stall), 32'(m_stall));

        @(posedge clk_16mhz);
        if (reset) begin
            model_reset();
        end else begin
            push = bus.wr_valid && sz < WQ_DEPTH;
            drop = bus.wr_valid && sz == WQ_DEPTH;
            evt  = bus.rd_req && sz != 0;
            if (exp_wen) void'(mq.pop_front());
            if (push) mq.push_back('{a: bus.wr_addr, d: bus.wr_data});
            m_rd_valid = bus.rd_req;
            if (bus.rd_req) m_rd_addr = bus.rd_addr;
            if (stat_clear) m_drop = drop ? 16'd1 : 16'd0;
            else if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_cnt = !evt ? 0 : (m_cnt < STALL_LIMIT ? m_cnt + 1 : m_cnt);
            if (m_cnt == STALL_LIMIT) m_stall = 1'b1;
            else if (stat_clear) m_stall = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input logic rr, input logic [ADDR_W-1:0] ra, input logic wv,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic sc, input logic rst);
        bus.rd_req      = rr;
        bus.rd_addr     = ra;
        bus.wr_valid    = wv;
        bus.wr_addr     = wa;
        bus.wr_data     = wd;
        bus.mem_rd_data = DATA_W'($urandom);
        stat_clear      = sc;
        reset           = rst;
        tick();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_valid = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.mem_rd_data = '0;
        stat_clear = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk_16mhz);
        #1;
        model_reset();
        chk("rst_level", 32'(wq_level), 32'd0);
        chk("rst_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        chk("rst_drop", 32'(wr_drop_count), 32'd0);
        chk("rst_stall", 32'(wr_stall), 32'd0);

        // Single write drains the following cycle
        drive(1'b0, '0, 1'b1, 14'h0010, 16'hA5A5, 1'b0, 1'b0);
        chk("t1_level", 32'(wq_level), 32'd1);
        idle(2);
        chk("t1_level_after", 32'(wq_level), 32'd0);

        // Writes held off by continuous reads, then drain in order
        drive(1'b0, '0, 1'b1, 14'h0001, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 14'h0100, 1'b1, 14'h0002, 16'h2222, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 8; i++) drive(1'b1, 14'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t2_level", 32'(wq_level), 32'd2);
        idle(3);

        // Read address passthrough and one-cycle data
        drive(1'b1, 14'h1234, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t3_rd_valid", 32'(bus.rd_valid), 32'd1);
        idle(2);

        // Overflow under read pressure
        for (int unsigned i = 0; i < 6; i++)
            drive(1'b1, 14'h0200, 1'b1, 14'(14'h0300 + i), 16'(16'hB000 + i), 1'b0, 1'b0);
        chk("t4_level", 32'(wq_level), 32'd4);
        chk("t4_ready", 32'(bus.wr_ready), 32'd0);
        chk("t4_drop", 32'(wr_drop_count), 32'd2);
        idle(5);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);

        // Stall flag after STALL_LIMIT blocked cycles, sticky until stat_clear
        drive(1'b0, '0, 1'b1, 14'h0400, 16'hC0DE, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 7; i++) drive(1'b1, 14'h0010, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t5_stall_pre", 32'(wr_stall), 32'd0);
        drive(1'b1, 14'h0010, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t5_stall_set", 32'(wr_stall), 32'd1);
        idle(2);
        chk("t5_stall_hold", 32'(wr_stall), 32'd1);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("t5_stall_clr", 32'(wr_stall), 32'd0);

        // Mid-operation reset discards queued writes
        for (int unsigned i = 0; i < 3; i++)
            drive(1'b1, 14'h0020, 1'b1, 14'(14'h0500 + i), 16'(16'hD000 + i), 1'b0, 1'b0);
        drive(1'b1, 14'h0020, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("t6_level", 32'(wq_level), 32'd0);
        chk("t6_ready", 32'(bus.wr_ready), 32'd1);
        chk("t6_drop", 32'(wr_drop_count), 32'd0);
        chk("t6_stall", 32'(wr_stall), 32'd0);
        idle(3);

        // Random traffic
        for (int unsigned i = 0; i < 500; i++)
            drive($urandom_range(0, 2) != 0, 14'($urandom), $urandom_range(0, 1) == 1,
                  14'($urandom), 16'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
